// File: rtl/if3_redirect_unit.sv
// if3_redirect_unit: fetch-stage-3 predecode, first-control-slot prediction merge,
// NLP redirect and deferred redirect for delay slots that land in the next group.
module if3_redirect_unit #(
  parameter int FETCH_WIDTH = 4,
  parameter int SLOT_W = $clog2(FETCH_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     pause,
  input  logic [FETCH_WIDTH-1:0]   in_valid,
  input  logic [31:0]              in_pc,
  input  logic [32*FETCH_WIDTH-1:0] in_inst,
  input  logic                     nlp_valid,
  input  logic [SLOT_W-1:0]        nlp_slot,
  input  logic [31:0]              nlp_target,
  input  logic                     bpd_valid,
  input  logic                     bpd_taken,
  input  logic [31:0]              bpd_target,
  output logic [FETCH_WIDTH-1:0]   out_valid,
  output logic [FETCH_WIDTH-1:0]   out_is_ctrl,
  output logic [FETCH_WIDTH-1:0]   out_pred_taken,
  output logic [31:0]              out_pred_addr,
  output logic                     redirect,
  output logic [31:0]              redirect_pc,
  output logic                     flush_req,
  output logic                     ds_pending
);
  typedef enum logic {IDLE, WAIT_DS} state_t;
  state_t state_q, state_d;
  logic [31:0] ds_q, ds_d, pc4_c, tgt, ft;
  logic [25:0] imm_c;
  logic [FETCH_WIDTH-1:0] dj, ij, br;
  logic [FETCH_WIDTH:0] vx;
  logic [SLOT_W:0] c;
  logic kd, ki, kb, c1v, nlp_hit, taken, nlp_ok, go;
  // J/JAL = 00001x, JR/JALR = op 0 funct 00100x, branches = 0001xx or REGIMM with rt = x000x
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      dj[i] = in_valid[i] && in_inst[32*i+27 +: 5] == 5'b00001;
      ij[i] = in_valid[i] && in_inst[32*i+26 +: 6] == 6'd0 && in_inst[32*i+1 +: 5] == 5'b00100;
      br[i] = in_valid[i] && (in_inst[32*i+28 +: 4] == 4'b0001 ||
              (in_inst[32*i+26 +: 6] == 6'd1 && in_inst[32*i+17 +: 3] == 3'd0));
    end
  end
  assign out_is_ctrl = dj | ij | br;
  assign vx = {1'b0, in_valid};
  // Scan downward so the lowest control slot is the one left standing
  always_comb begin
    {kd, ki, kb, c1v} = 4'b0;
    c = '0;
    imm_c = '0;
    pc4_c = '0;
    ft = in_pc;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (out_is_ctrl[i]) begin
        {kd, ki, kb} = {dj[i], ij[i], br[i]};
        c = (SLOT_W+1)'(i);
        c1v = vx[i+1];
        imm_c = in_inst[32*i +: 26];
        pc4_c = in_pc + 32'(4*i+4);
      end
    end
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (in_valid[i]) ft = in_pc + 32'(4*i+4);
  end
  assign nlp_hit = nlp_valid && (kd || ki || kb) && nlp_slot == c[SLOT_W-1:0];
  assign taken = kd || (ki && (bpd_valid || nlp_hit)) || (kb && (bpd_valid ? bpd_taken : nlp_hit));
  assign tgt = kd ? {pc4_c[31:28], imm_c, 2'b00} :
               kb ? pc4_c + {{14{imm_c[15]}}, imm_c[15:0], 2'b00} :
               bpd_valid ? bpd_target : nlp_target;
  assign nlp_ok = taken ? nlp_hit && nlp_target == tgt : !nlp_valid;
  assign go = !rst && !flush && !pause;
  always_comb begin
    state_d = state_q;
    ds_d = ds_q;
    out_valid = in_valid;
    out_pred_taken = '0;
    out_pred_addr = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    if (state_q == IDLE) begin
      out_pred_taken = taken ? FETCH_WIDTH'(1) << c : '0;
      out_pred_addr = taken ? tgt : '0;
      out_valid = taken && c1v ? in_valid & ((FETCH_WIDTH'(1) << (c + 2'd2)) - FETCH_WIDTH'(1)) : in_valid;
      if (go && in_valid[0]) begin
        redirect = taken ? c1v && !nlp_ok : !nlp_ok;
        redirect_pc = redirect ? (taken ? tgt : ft) : '0;
        if (taken && !c1v) begin
          state_d = WAIT_DS;
          ds_d = tgt;
        end
      end
    end else begin
      out_valid = FETCH_WIDTH'(in_valid[0]);
      if (go && in_valid[0]) begin
        redirect = 1'b1;
        redirect_pc = ds_q;
        state_d = IDLE;
      end
    end
    if (rst || flush) begin
      state_d = IDLE;
      ds_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ds_q <= '0;
    end else begin
      state_q <= state_d;
      ds_q <= ds_d;
    end
  end
  assign flush_req = redirect;
  assign ds_pending = state_q == WAIT_DS;
endmodule

// File: doc/if3_redirect_unit.md
# if3_redirect_unit

Parametrised fetch-stage-3 predecode and redirect unit for a FETCH_WIDTH-wide MIPS fetch group. It sits between the I-cache output registers and the IF3→ID registers. It predecodes every slot, selects the first control-transfer slot, and merges the BPD and NLP predictions. On disagreement with the NLP it raises a front-end redirect. It tracks delay slots that fall outside the current group with a two-state FSM, and releases the deferred redirect once the delay-slot instruction arrives.

## Interface

Parameters:
- FETCH_WIDTH, 4: slots per group, 2..8.
- SLOT_W, $clog2(FETCH_WIDTH): slot index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush from Ctrl.
- pause  in  1  pipeline stall from Ctrl.
- in_valid  in  FETCH_WIDTH  per-slot valid.
  - Valid slots are contiguous from slot 0.
- in_pc  in  32  PC of slot 0.
  - Slot i PC = in_pc + 4·i.
- in_inst  in  32·FETCH_WIDTH  instruction words; slot i occupies [32i+31:32i].
- nlp_valid  in  1  NLP predicted taken for this group.
- nlp_slot  in  SLOT_W  slot the NLP predicted taken.
- nlp_target  in  32  NLP target.
- bpd_valid  in  1  BPD prediction valid.
- bpd_taken  in  1  BPD direction.
- bpd_target  in  32  BPD/RAS target for indirect jumps.
- out_valid  out  FETCH_WIDTH  slot valid after kill masking.
- out_is_ctrl  out  FETCH_WIDTH  per-slot predecode: slot is a jump or branch.
- out_pred_taken  out  FETCH_WIDTH  final taken, one-hot or zero.
- out_pred_addr  out  32  final target of the taken slot; 0 if none.
- redirect  out  1  front-end redirect request.
- redirect_pc  out  32  redirect address.
- flush_req  out  1  request flush of IF1/IF2; equals redirect.
- ds_pending  out  1  FSM is in WAIT_DS.

## Operation

Predecode, per slot. Decoding is combinational and gated by in_valid.
- J/JAL, opcodes 2/3: direct jump. Target = {pc+4[31:28], idx, 2'b00}.
- JR/JALR, opcode 0, funct 8/9: indirect jump.
- BEQ/BNE/BLEZ/BGTZ (opcodes 4–7), and REGIMM (opcode 1) with rt ∈ {0,1,16,17}: branch. Target = pc + 4 + (sext(imm) << 2).

Decision:
- c = the lowest valid control slot. Only slot c is predicted; later control slots are predicted not taken.
- Prediction for slot c:
  - Direct jump: taken, decode target.
  - Indirect jump:
    - bpd_valid → taken, target bpd_target.
    - Otherwise, nlp_valid with nlp_slot == c → taken, target nlp_target.
    - Otherwise not taken.
  - Branch: direction is bpd_taken if bpd_valid, else (nlp_valid && nlp_slot == c). Target is the decode target.
- nlp_ok holds when either of the following is true:
  - Taken, with nlp_valid, nlp_slot == c and nlp_target == final target.
  - Not taken, with !nlp_valid.
- Fall-through address = PC of the highest valid slot + 4.

FSM states:
- IDLE, entered on reset or flush.
- WAIT_DS, which holds the 32-bit register ds_target.

In IDLE, with a valid group and neither pause nor flush:
- Taken, and slot c+1 is valid:
  - out_valid masks every slot > c+1.
  - redirect = !nlp_ok, redirect_pc = the final target.
- Taken, and slot c+1 is not valid (delay slot outside the group):
  - No redirect this cycle.
  - ds_target ← target; next state WAIT_DS.
  - This happens regardless of nlp_ok.
- Not taken, and !nlp_ok (NLP falsely taken): redirect = 1, redirect_pc = the fall-through address. No state change.
- Otherwise: no redirect, all valid slots pass.

In WAIT_DS, with neither pause nor flush:
- in_valid[0] = 1:
  - Slot 0 is the delay slot. out_valid = 0…01.
  - redirect = 1, redirect_pc = ds_target.
  - Next state IDLE.
  - Predecode decisions for this group are suppressed.
- in_valid[0] = 0: stay in WAIT_DS, out_valid = 0, no redirect.

Priority: rst > flush > pause > FSM.
- rst or flush: redirect = 0, and the FSM and ds_target clear next edge.
- pause: redirect = 0, and FSM and ds_target hold.
- out_valid, out_is_ctrl, out_pred_taken and out_pred_addr stay driven combinationally while paused.

## Timing

- Outputs are combinational from the inputs and state. Latency is 0 cycles.
- The FSM updates on posedge clk.
- Reset values:
  - State IDLE, ds_target 0, ds_pending 0.
  - With rst high: redirect, flush_req and redirect_pc are all 0.
- The deferred redirect asserts on the first non-paused cycle in WAIT_DS with in_valid[0] set. The minimum is 1 cycle after the branch group.
- Flush arriving in the same cycle as a WAIT_DS release: the flush wins, and no redirect is issued.
- A pause held for N cycles in WAIT_DS delays the release by N cycles. ds_target is unchanged.
- flush_req == redirect in every cycle.

## Test plan

- **In-group jump.** W=4, in_pc=0x1000, slot 1 = J idx=0x400, nlp_valid=0, all slots valid.
  - Response: out_valid=0111, out_pred_taken=0010, redirect=1, redirect_pc=0x00001000.
- **NLP agrees.**
  - Stimulus: slot 0 = BEQ with imm=4 at 0x2000; bpd_valid=1, bpd_taken=1; NLP reports slot 0 with target 0x2014.
  - Response: redirect=0, out_valid=0011.
- **NLP false-taken.**
  - Stimulus: no control instruction in the group; nlp_valid=1, nlp_slot=1; in_valid=0011, in_pc=0x3000.
  - Response: redirect=1, redirect_pc=0x3008.
- **Out-of-group delay slot.**
  - Stimulus: JR in slot 3, bpd_valid=1, bpd_target=0x8000.
  - Response in that cycle: redirect=0, and ds_pending=1 next cycle.
  - Then: one bubble with in_valid=0, then a full group.
  - Response: out_valid=0001, redirect_pc=0x8000, ds_pending=0 on the following cycle.
- **Pause then flush in WAIT_DS.**
  - Pause for 3 cycles: ds_pending stays 1, redirect=0.
  - Then flush together with in_valid[0]=1: redirect=0, ds_pending=0 next cycle.
- **Reset mid-WAIT_DS.** Assert rst: next cycle ds_pending=0 and ds_target=0. The following valid group is processed as IDLE.
